// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard; reads are combinational, all state updates on negedge clk.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [DATA_W-1:0] data,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] resreg,
  input  logic              reserve,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  output logic              busy1,
  output logic              busy2,
  output logic              res_conflict,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, rs_en, inc, dec;
  logic rd1_zero, rd2_zero;
  logic [DATA_W-1:0] st_rd1, st_rd2;
  logic st_busy1, st_busy2;

  // Register 0 swallows writes and reserves when hardwired to zero.
  assign wr_en    = regwrite && !((ZERO_REG != 0) && (writereg == '0));
  assign rs_en    = reserve  && !((ZERO_REG != 0) && (resreg   == '0));
  assign rd1_zero = (ZERO_REG != 0) && (readreg1 == '0);
  assign rd2_zero = (ZERO_REG != 0) && (readreg2 == '0);

  assign inc = rs_en && !busy_q[resreg];
  assign dec = wr_en && busy_q[writereg] && !(rs_en && (resreg == writereg));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[writereg] = data;
      busy_d[writereg] = 1'b0;
    end
    // Reserve applied after the write so a same-address reservation wins.
    if (rs_en) begin
      busy_d[resreg] = 1'b1;
    end
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign st_rd1   = rd1_zero ? '0 : regs_q[readreg1];
  assign st_rd2   = rd2_zero ? '0 : regs_q[readreg2];
  assign st_busy1 = !rd1_zero && busy_q[readreg1];
  assign st_busy2 = !rd2_zero && busy_q[readreg2];

`ifdef REGFILE_BYPASS_EN
  logic byp1, byp2;

  assign byp1 = !clr && wr_en && (readreg1 == writereg);
  assign byp2 = !clr && wr_en && (readreg2 == writereg);

  always_comb begin
    read1 = clr ? '0 : (byp1 ? data : st_rd1);
    read2 = clr ? '0 : (byp2 ? data : st_rd2);
    busy1 = byp1 ? (rs_en && (resreg == readreg1)) : st_busy1;
    busy2 = byp2 ? (rs_en && (resreg == readreg2)) : st_busy2;
  end
`else
  always_comb begin
    read1 = st_rd1;
    read2 = st_rd2;
    busy1 = st_busy1;
    busy2 = st_busy2;
  end
`endif

  assign res_conflict = rs_en && busy_q[resreg];
  assign busy_count   = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expected outputs, a monitor on posedge pops and compares.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] readreg1, readreg2, writereg, resreg;
  logic [7:0] data;
  logic       regwrite, reserve;

  logic [7:0] read1, read2, z_read1, z_read2;
  logic       busy1, busy2, conf, z_busy1, z_busy2, z_conf;
  logic [2:0] cnt, z_cnt;

  typedef struct {
    string      name;
    bit         z;
    logic [7:0] r1;
    logic       b1;
    logic [7:0] r2;
    logic       b2;
    logic       cf;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic [21:0] act_v, exp_v;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut (
    .clk(clk), .clr(clr), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .data(data), .regwrite(regwrite),
    .resreg(resreg), .reserve(reserve),
    .read1(read1), .read2(read2), .busy1(busy1), .busy2(busy2),
    .res_conflict(conf), .busy_count(cnt)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) dut_z (
    .clk(clk), .clr(clr), .readreg1(readreg1), .readreg2(readreg2),
    .writereg(writereg), .data(data), .regwrite(regwrite),
    .resreg(resreg), .reserve(reserve),
    .read1(z_read1), .read2(z_read2), .busy1(z_busy1), .busy2(z_busy2),
    .res_conflict(z_conf), .busy_count(z_cnt)
  );

  // Monitor: posedge is mid-cycle for this negedge design.
  always @(posedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      act_v = mon_e.z ? {z_read1, z_busy1, z_read2, z_busy2, z_conf, z_cnt}
                      : {read1, busy1, read2, busy2, conf, cnt};
      exp_v = {mon_e.r1, mon_e.b1, mon_e.r2, mon_e.b2, mon_e.cf, mon_e.cnt};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s: got r1=%h b1=%b r2=%h b2=%b conf=%b cnt=%0d, expected r1=%h b1=%b r2=%h b2=%b conf=%b cnt=%0d",
                 mon_e.name, act_v[21:14], act_v[13], act_v[12:5], act_v[4], act_v[3], act_v[2:0],
                 mon_e.r1, mon_e.b1, mon_e.r2, mon_e.b2, mon_e.cf, mon_e.cnt);
      end
    end
  end

  task automatic cyc(input logic [1:0] r1a, input logic [1:0] r2a,
                     input logic we, input logic [1:0] wa, input logic [7:0] d,
                     input logic re, input logic [1:0] ra, input logic c);
    @(negedge clk);
    #1;
    readreg1 = r1a; readreg2 = r2a;
    regwrite = we;  writereg = wa; data = d;
    reserve  = re;  resreg   = ra; clr  = c;
  endtask

  task automatic ex(input string name, input bit z, input logic [7:0] r1, input logic b1,
                    input logic [7:0] r2, input logic b2, input logic cf, input logic [2:0] c);
    exp_t e;
    e.name = name; e.z = z; e.r1 = r1; e.b1 = b1; e.r2 = r2; e.b2 = b2; e.cf = cf; e.cnt = c;
    exp_q.push_back(e);
  endtask

  initial begin
    readreg1 = '0; readreg2 = '0; writereg = '0; resreg = '0;
    data = '0; regwrite = 1'b0; reserve = 1'b0; clr = 1'b1;

    cyc(0, 0, 0, 0, 8'h00, 0, 0, 1);
    // Populate state, then clear with competing write/reserve at the same edge.
    cyc(0, 0, 1, 0, 8'h11, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'h22, 1, 1, 0);
    cyc(0, 0, 1, 2, 8'h33, 1, 3, 0);
    cyc(0, 0, 1, 3, 8'h44, 0, 0, 0);
    cyc(0, 0, 1, 3, 8'h99, 1, 2, 1);

    cyc(0, 1, 0, 0, 8'h00, 0, 0, 0);
    ex("rst_a", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    ex("rst_a_z", 1, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(2, 3, 0, 0, 8'h00, 0, 0, 0);
    ex("rst_b", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    ex("rst_b_z", 1, 8'h00, 0, 8'h00, 0, 0, 0);

    cyc(0, 1, 1, 2, 8'hA5, 0, 0, 0);
    ex("wr_r2", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(2, 1, 0, 0, 8'h00, 0, 0, 0);
    ex("rd_r2", 0, 8'hA5, 0, 8'h00, 0, 0, 0);

    cyc(1, 3, 0, 0, 8'h00, 1, 1, 0);
    ex("res_r1", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(1, 3, 0, 0, 8'h00, 1, 3, 0);
    ex("res_r3", 0, 8'h00, 1, 8'h00, 0, 0, 1);
    cyc(1, 3, 0, 0, 8'h00, 0, 0, 0);
    ex("cnt2", 0, 8'h00, 1, 8'h00, 1, 0, 2);
    cyc(2, 3, 1, 1, 8'h3C, 0, 0, 0);
    ex("wr_r1", 0, 8'hA5, 0, 8'h00, 1, 0, 2);
    cyc(1, 3, 0, 0, 8'h00, 0, 0, 0);
    ex("rel_r1", 0, 8'h3C, 0, 8'h00, 1, 0, 1);

    cyc(2, 1, 0, 0, 8'h00, 1, 2, 0);
    ex("res_r2", 0, 8'hA5, 0, 8'h3C, 0, 0, 1);
    cyc(2, 1, 0, 0, 8'h00, 1, 2, 0);
    ex("res_busy", 0, 8'hA5, 1, 8'h3C, 0, 1, 2);
    cyc(3, 1, 1, 2, 8'h77, 1, 2, 0);
    ex("wr_res_r2", 0, 8'h00, 1, 8'h3C, 0, 1, 2);
    cyc(2, 3, 0, 0, 8'h00, 0, 0, 0);
    ex("r2_77", 0, 8'h77, 1, 8'h00, 1, 0, 2);

    // Release r3 and reserve r1 at one edge: net count change zero.
    cyc(0, 1, 1, 3, 8'h12, 1, 1, 0);
    ex("inc_dec", 0, 8'h00, 0, 8'h3C, 0, 0, 2);
    cyc(3, 1, 0, 0, 8'h00, 0, 0, 0);
    ex("inc_dec_b", 0, 8'h12, 0, 8'h3C, 1, 0, 2);

    cyc(3, 2, 1, 3, 8'h5A, 0, 0, 0);
    ex("byp_r3", 0, BYP ? 8'h5A : 8'h12, 0, 8'h77, 1, 0, 2);
    cyc(2, 3, 1, 2, 8'h66, 1, 2, 0);
    ex("byp_res_r2", 0, BYP ? 8'h66 : 8'h77, 1, 8'h5A, 0, 1, 2);
    cyc(3, 2, 0, 0, 8'h00, 0, 0, 0);
    ex("after_byp", 0, 8'h5A, 0, 8'h66, 1, 0, 2);

    cyc(0, 2, 1, 2, 8'h01, 0, 0, 0);
    ex("rel_r2", 0, 8'h00, 0, BYP ? 8'h01 : 8'h66, BYP ? 1'b0 : 1'b1, 0, 2);
    cyc(1, 2, 0, 0, 8'h00, 0, 0, 0);
    ex("rel_r2_b", 0, 8'h3C, 1, 8'h01, 0, 0, 1);

    cyc(0, 1, 1, 3, 8'h02, 0, 0, 0);
    ex("wr_free", 0, 8'h00, 0, 8'h3C, 1, 0, 1);
    cyc(3, 1, 0, 0, 8'h00, 0, 0, 0);
    ex("wr_free_b", 0, 8'h02, 0, 8'h3C, 1, 0, 1);

    cyc(0, 1, 1, 0, 8'hFF, 1, 0, 0);
    ex("z_wr", 1, 8'h00, 0, 8'h3C, 1, 0, 1);
    ex("nz_wr", 0, BYP ? 8'hFF : 8'h00, BYP, 8'h3C, 1, 0, 1);
    cyc(0, 1, 0, 0, 8'h00, 1, 0, 0);
    ex("z_res", 1, 8'h00, 0, 8'h3C, 1, 0, 1);
    ex("nz_res", 0, 8'hFF, 1, 8'h3C, 1, 1, 2);

    cyc(0, 1, 1, 1, 8'hAB, 1, 3, 1);
    cyc(0, 1, 0, 0, 8'h00, 0, 0, 0);
    ex("clr2_a", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    ex("clr2_a_z", 1, 8'h00, 0, 8'h00, 0, 0, 0);
    cyc(2, 3, 0, 0, 8'h00, 0, 0, 0);
    ex("clr2_b", 0, 8'h00, 0, 8'h00, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the 8-bit, 4-entry CPU register file.
- Generalised data width and register count, two combinational read ports, one write port.
- Per-register busy scoreboard: the decode stage reserves a destination; writeback releases it.
- Decode uses the busy flags to stall on RAW hazards. Sits between decode (read/reserve) and writeback (write).

Parameters:
DATA_W, 8, register data width in bits
ADDR_W, 2, register address width; NREGS = 2**ADDR_W entries
ZERO_REG, 0, 1 = register 0 hardwired to zero (reads 0, never busy, writes/reserves ignored)

Ports:
clk  input  1  clock; all state updates on the falling edge
clr  input  1  synchronous active-high reset, sampled on falling edge of clk
readreg1  input  ADDR_W  read port 1 address
readreg2  input  ADDR_W  read port 2 address
writereg  input  ADDR_W  write address
data  input  DATA_W  write data
regwrite  input  1  write enable; also releases busy[writereg]
resreg  input  ADDR_W  reserve address
reserve  input  1  reserve enable; sets busy[resreg]
read1  output  DATA_W  contents of readreg1 (combinational)
read2  output  DATA_W  contents of readreg2 (combinational)
busy1  output  1  busy[readreg1] (combinational)
busy2  output  1  busy[readreg2] (combinational)
res_conflict  output  1  reserve & busy[resreg] (combinational)
busy_count  output  ADDR_W+1  number of busy registers (registered)

Behaviour:
- State: regs[NREGS] of DATA_W, busy[NREGS] bits, busy_count. All updated only on negedge clk.
- clr=1 at edge:
  - All regs <= 0, all busy <= 0, busy_count <= 0.
  - clr overrides regwrite and reserve at the same edge.
  - Outputs after reset: read1/read2 = 0, busy1/busy2 = 0, res_conflict = 0, busy_count = 0.
- regwrite=1: regs[writereg] <= data; busy[writereg] <= 0.
- reserve=1: busy[resreg] <= 1.
- Same edge, regwrite and reserve to the same address: data written, busy ends 1 (new reservation wins).
- Reserve of an already-busy register: busy stays 1; res_conflict=1 during that cycle. No other effect; decode must stall.
- Write to a non-busy register: legal. Data written, busy stays 0.
- busy_count next = busy_count + inc - dec:
  - inc = 1 if reserve targets a non-busy register.
  - dec = 1 if regwrite targets a busy register and reserve does not target the same address this edge.
  - Both may apply at one edge (net 0).
  - Never exceeds NREGS and never underflows, by construction.
- Reads are combinational from current state: a write becomes visible after the falling edge (zero-latency read of stored value).
- ZERO_REG=1, address 0:
  - read = 0 and busy = 0.
  - Writes and reserves to address 0 are ignored: no busy set, no count change, res_conflict = 0.
- Unknown/X addresses are not specified; the bench drives only known values.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - When regwrite=1 and readregN == writereg (excluding address 0 when ZERO_REG=1), readN = data combinationally in the same cycle.
  - busyN = 0 for that port, unless reserve=1 to the same address, in which case busyN = 1.
  - clr=1 suppresses bypass: readN = 0 while clr is asserted.
- Undefined: no forwarding; readN and busyN reflect stored state only until the falling edge.

Test Plan:
1. clr=1 for one edge after random writes -> all 4 regs read 0, busy1=busy2=0, busy_count=0.
2. Write regwrite=1, writereg=2, data=8'hA5; next cycle readreg1=2 -> read1=8'hA5, busy1=0.
3. Reserve r1 and r3 on successive edges -> busy_count=2, busy1=1 with readreg1=1. Write r1=8'h3C -> busy_count=1, read1=8'h3C, busy1=0.
4. Reserve r2 while busy -> res_conflict=1, busy_count unchanged. Same-edge write+reserve to r2 with data=8'h77 -> read 8'h77, busy stays 1, count unchanged.
5. ZERO_REG=1: write 8'hFF to r0 and reserve r0 -> read1=0, busy1=0, busy_count=0.
6. REGFILE_BYPASS_EN, readreg1=writereg=3, data=8'h5A, regwrite=1 -> read1=8'h5A before the edge. Without the macro -> old value until the edge.
